// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding/writeback inputs and EX/MEM outputs of the execute stage.
// The upstream pipeline drives through master; execute_stage sits on slave.
interface execute_stage_if;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        ALUSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [31:0] ResultW;

    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallEx;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
        output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
        output ForwardA_E, ForwardB_E, ResultW,
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M,
        input  PCSrcE, PCTargetE, StallEx
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
        input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
        input  ForwardA_E, ForwardB_E, ResultW,
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M,
        output PCSrcE, PCTargetE, StallEx
    );
endinterface

// File: rtl/execute_stage.sv
// Pipeline execute stage: forwarding muxes, single-cycle ALU, branch resolution,
// a 32-step shift-add multiplier that stalls the pipe, and the EX/MEM register.
module execute_stage (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;

    mul_state_t  r_state;
    mul_state_t  w_state_next;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;

    logic        r_reg_write_m;
    logic        r_mem_write_m;
    logic        r_result_src_m;
    logic [4:0]  r_rd_m;
    logic [31:0] r_alu_result_m;
    logic [31:0] r_write_data_m;
    logic [31:0] r_pc_plus4_m;

    logic [31:0] w_src_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_result;
    logic        w_zero;
    logic        w_is_mul;
    logic        w_stall;
    logic        w_mul_start;
    logic        w_mul_step;
    logic        w_mul_done;
    logic [63:0] w_addend;

    // Forwarding: 10 takes the EX/MEM result, 01 the writeback result, 00/11 the register file.
    always_comb begin
        w_src_a = bus.RD1_E;
        case (bus.ForwardA_E)
            2'b10:   w_src_a = r_alu_result_m;
            2'b01:   w_src_a = bus.ResultW;
            default: w_src_a = bus.RD1_E;
        endcase
    end

    always_comb begin
        w_fwd_b = bus.RD2_E;
        case (bus.ForwardB_E)
            2'b10:   w_fwd_b = r_alu_result_m;
            2'b01:   w_fwd_b = bus.ResultW;
            default: w_fwd_b = bus.RD2_E;
        endcase
    end

    assign w_src_b  = bus.ALUSrcE ? bus.Imm_Ext_E : w_fwd_b;
    assign w_is_mul = (bus.ALUControlE == ALU_MUL);

    // The mul encoding has no single-cycle result; it only feeds Zero, which is masked below.
    always_comb begin
        w_alu_result = w_src_a + w_src_b;
        case (bus.ALUControlE)
            ALU_ADD: w_alu_result = w_src_a + w_src_b;
            ALU_SUB: w_alu_result = w_src_a - w_src_b;
            ALU_AND: w_alu_result = w_src_a & w_src_b;
            ALU_OR:  w_alu_result = w_src_a | w_src_b;
            ALU_SLT: w_alu_result = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_MUL: w_alu_result = 32'd0;
            default: w_alu_result = w_src_a + w_src_b;
        endcase
    end

    assign w_zero        = (w_alu_result == 32'd0);
    assign bus.PCSrcE    = bus.BranchE & w_zero & ~w_is_mul;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    // Multiplier FSM: one IDLE cycle to latch operands, 32 BUSY steps, one DONE cycle to retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mul) begin
                    w_stall      = 1'b1;
                    w_mul_start  = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall    = w_is_mul;
                w_mul_step = 1'b1;
                if (r_count == 5'd31) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_mul_done   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.StallEx = w_stall;

    // Multiplier consumed LSB first: bit r_count of B adds A shifted into place.
    assign w_addend = r_mul_b[r_count] ? ({32'd0, r_mul_a} << r_count) : 64'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 5'd0;
            r_acc   <= 64'd0;
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
        end else if (w_mul_start) begin
            r_count <= 5'd0;
            r_acc   <= 64'd0;
            r_mul_a <= w_src_a;
            r_mul_b <= w_src_b;
        end else if (w_mul_step) begin
            r_count <= r_count + 5'd1;
            r_acc   <= r_acc + w_addend;
        end
    end

    // EX/MEM register: bubble while stalled, product on DONE, ALU result otherwise.
    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 1'b0;
            r_rd_m         <= 5'd0;
            r_alu_result_m <= 32'd0;
            r_write_data_m <= 32'd0;
            r_pc_plus4_m   <= 32'd0;
        end else if (w_mul_done) begin
            r_reg_write_m  <= bus.RegWriteE;
            r_mem_write_m  <= bus.MemWriteE;
            r_result_src_m <= bus.ResultSrcE;
            r_rd_m         <= bus.RD_E;
            r_alu_result_m <= r_acc[31:0];
            r_write_data_m <= r_mul_b;
            r_pc_plus4_m   <= bus.PCPlus4E;
        end else begin
            r_reg_write_m  <= bus.RegWriteE;
            r_mem_write_m  <= bus.MemWriteE;
            r_result_src_m <= bus.ResultSrcE;
            r_rd_m         <= bus.RD_E;
            r_alu_result_m <= w_alu_result;
            r_write_data_m <= w_fwd_b;
            r_pc_plus4_m   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM  = r_reg_write_m;
    assign bus.MemWriteM  = r_mem_write_m;
    assign bus.ResultSrcM = r_result_src_m;
    assign bus.RD_M       = r_rd_m;
    assign bus.ALUResultM = r_alu_result_m;
    assign bus.WriteDataM = r_write_data_m;
    assign bus.PCPlus4M   = r_pc_plus4_m;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, multi-cycle mul and
// reset sequences, and randomized traffic against a plain-arithmetic reference model.
module tb_execute_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] model_alu_m;

    execute_stage_if bus ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pce;
        logic [31:0] pcp4;
        logic [31:0] resw;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        regw;
        logic        memw;
        logic        ressrc;
        logic        alusrc;
        logic        branch;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] exp_res;
        logic [31:0] exp_wd;
        logic [31:0] exp_tgt;
        logic        exp_pcsrc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mkop(input logic [2:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic alusrc, input logic [1:0] fa,
                                 input logic [1:0] fb, input logic [31:0] resw, input logic branch,
                                 input logic [31:0] pce, input logic [4:0] rd, input logic regw);
        op_t o;
        o.ctrl = ctrl; o.rd1 = rd1; o.rd2 = rd2; o.imm = imm; o.alusrc = alusrc;
        o.fa = fa; o.fb = fb; o.resw = resw; o.branch = branch; o.pce = pce;
        o.rd = rd; o.regw = regw; o.memw = 1'b0; o.ressrc = 1'b0; o.pcp4 = 32'd0;
        return o;
    endfunction

    task automatic apply(input op_t o);
        bus.ALUControlE = o.ctrl;
        bus.RD1_E       = o.rd1;
        bus.RD2_E       = o.rd2;
        bus.Imm_Ext_E   = o.imm;
        bus.PCE         = o.pce;
        bus.PCPlus4E    = o.pcp4;
        bus.ResultW     = o.resw;
        bus.RD_E        = o.rd;
        bus.ForwardA_E  = o.fa;
        bus.ForwardB_E  = o.fb;
        bus.RegWriteE   = o.regw;
        bus.MemWriteE   = o.memw;
        bus.ResultSrcE  = o.ressrc;
        bus.ALUSrcE     = o.alusrc;
        bus.BranchE     = o.branch;
    endtask

    function automatic logic [31:0] ctl_bundle();
        return {24'd0, bus.RD_M, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM};
    endfunction

    function automatic logic [31:0] exp_ctl(input op_t o);
        return {24'd0, o.rd, o.regw, o.memw, o.ressrc};
    endfunction

    // Reference model: operand selection and ALU semantics straight from the operation definitions.
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] resw);
        if (sel == 2'b10) return model_alu_m;
        if (sel == 2'b01) return resw;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c == 3'd1) return a - b;
        if (c == 3'd2) return a & b;
        if (c == 3'd3) return a | b;
        if (c == 3'd5) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return a + b;
    endfunction

    task automatic run_single(input op_t o, input logic [31:0] exp_res, input logic [31:0] exp_wd,
                              input logic [31:0] exp_tgt, input logic exp_pcsrc, input string nm);
        apply(o);
        #1;
        chk({nm, "_pcsrc"}, {31'd0, bus.PCSrcE}, {31'd0, exp_pcsrc});
        chk({nm, "_target"}, bus.PCTargetE, exp_tgt);
        chk({nm, "_stall"}, {31'd0, bus.StallEx}, 32'd0);
        tick();
        chk({nm, "_result"}, bus.ALUResultM, exp_res);
        chk({nm, "_wdata"}, bus.WriteDataM, exp_wd);
        chk({nm, "_ctl"}, ctl_bundle(), exp_ctl(o));
        chk({nm, "_pcp4"}, bus.PCPlus4M, o.pcp4);
        model_alu_m = exp_res;
        $display("txn %s ctrl=%0d res=%h wd=%h pcsrc=%0d", nm, o.ctrl, bus.ALUResultM, bus.WriteDataM, bus.PCSrcE);
    endtask

    // Mul: count stalled cycles (bounded), check bubbles, then check the retired product.
    task automatic run_mul(input op_t o, input logic [31:0] resw_late, input logic [31:0] exp_res,
                           input logic [31:0] exp_wd, input string nm);
        int stalls;
        stalls = 0;
        apply(o);
        #1;
        chk({nm, "_pcsrc_masked"}, {31'd0, bus.PCSrcE}, 32'd0);
        while (bus.StallEx && stalls < 40) begin
            stalls++;
            tick();
            if (stalls == 1) bus.ResultW = resw_late;
            #1;
            chk({nm, "_bubble_res"}, bus.ALUResultM | bus.WriteDataM | bus.PCPlus4M, 32'd0);
            chk({nm, "_bubble_ctl"}, ctl_bundle(), 32'd0);
        end
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'd33);
        tick();
        chk({nm, "_product"}, bus.ALUResultM, exp_res);
        chk({nm, "_wdata"}, bus.WriteDataM, exp_wd);
        chk({nm, "_ctl"}, ctl_bundle(), exp_ctl(o));
        chk({nm, "_pcp4"}, bus.PCPlus4M, o.pcp4);
        model_alu_m = exp_res;
        $display("txn %s mul res=%h wd=%h stalls=%0d", nm, bus.ALUResultM, bus.WriteDataM, stalls);
    endtask

    task automatic addv(input op_t o, input logic [31:0] res, input logic [31:0] wd,
                        input logic [31:0] tgt, input logic pcsrc);
        vec_t v;
        v.op = o; v.exp_res = res; v.exp_wd = wd; v.exp_tgt = tgt; v.exp_pcsrc = pcsrc;
        vq.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        logic [31:0] sa, sb, res, wd;
        logic [63:0] prod;
        logic [2:0]  codes [7];
        checks      = 0;
        failures    = 0;
        model_alu_m = 32'd0;

        // Directed vectors; order matters because some forward the previous ALUResultM.
        addv(mkop(3'd0, 32'd5, 32'h11, 32'd7, 1'b1, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd3, 1'b1), 32'd12, 32'h11, 32'd7, 1'b0);
        addv(mkop(3'd0, 32'd20, 32'd0, 32'd0, 1'b1, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd4, 1'b1), 32'd20, 32'd0, 32'd0, 1'b0);
        addv(mkop(3'd1, 32'd99, 32'd77, 32'd0, 1'b0, 2'b10, 2'b01, 32'd8, 1'b0, 32'd0, 5'd5, 1'b1), 32'd12, 32'd8, 32'd0, 1'b0);
        addv(mkop(3'd1, 32'd50, 32'd8, 32'd0, 1'b0, 2'b11, 2'b11, 32'd1, 1'b0, 32'd0, 5'd6, 1'b0), 32'd42, 32'd8, 32'd0, 1'b0);
        addv(mkop(3'd1, 32'd9, 32'd9, 32'h20, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 32'h100, 5'd0, 1'b0), 32'd0, 32'd9, 32'h120, 1'b1);
        addv(mkop(3'd1, 32'd9, 32'd8, 32'hFFFFFFF0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 32'h200, 5'd0, 1'b0), 32'd1, 32'd8, 32'h1F0, 1'b0);
        addv(mkop(3'd2, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd7, 1'b1), 32'h00F0000F, 32'h0FF00F0F, 32'd0, 1'b0);
        addv(mkop(3'd3, 32'hF0000000, 32'h0000000F, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd8, 1'b1), 32'hF000000F, 32'h0000000F, 32'd0, 1'b0);
        addv(mkop(3'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd9, 1'b1), 32'd1, 32'd1, 32'd0, 1'b0);
        addv(mkop(3'd5, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 32'd0, 5'd10, 1'b1), 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
        addv(mkop(3'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd11, 1'b1), 32'd1, 32'd2, 32'd0, 1'b0);
        addv(mkop(3'd1, 32'd0, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd12, 1'b1), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        addv(mkop(3'd4, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd13, 1'b1), 32'd7, 32'd4, 32'd0, 1'b0);
        addv(mkop(3'd7, 32'd10, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd14, 1'b1), 32'd15, 32'd5, 32'd0, 1'b0);
        addv(mkop(3'd0, 32'd1, 32'd2, 32'd23, 1'b1, 2'b01, 2'b10, 32'd100, 1'b0, 32'd0, 5'd15, 1'b1), 32'd123, 32'd15, 32'd23, 1'b0);
        for (int i = 0; i < vq.size(); i++) begin
            vq[i].op.pcp4   = 32'h1000 + 32'(i) * 32'd4;
            vq[i].op.memw   = i[0];
            vq[i].op.ressrc = i[1];
        end

        // Reset held two cycles with live inputs.
        rst = 1'b1;
        o = mkop(3'd0, 32'd5, 32'd6, 32'd7, 1'b0, 2'b00, 2'b00, 32'd9, 1'b1, 32'h40, 5'd3, 1'b1);
        o.memw = 1'b1; o.ressrc = 1'b1; o.pcp4 = 32'h44;
        apply(o);
        tick();
        tick();
        chk("rst_result", bus.ALUResultM, 32'd0);
        chk("rst_wdata", bus.WriteDataM, 32'd0);
        chk("rst_pcp4", bus.PCPlus4M, 32'd0);
        chk("rst_ctl", ctl_bundle(), 32'd0);
        chk("rst_stall", {31'd0, bus.StallEx}, 32'd0);
        $display("txn reset outputs res=%h stall=%0d", bus.ALUResultM, bus.StallEx);
        rst = 1'b0;

        foreach (vq[i]) begin
            run_single(vq[i].op, vq[i].exp_res, vq[i].exp_wd, vq[i].exp_tgt, vq[i].exp_pcsrc, $sformatf("vec%0d", i));
        end

        // 0xFFFFFFFF x 3, then a back-to-back mul whose forwarded operands must be latched.
        o = mkop(3'd6, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 32'd0, 5'd7, 1'b1);
        o.pcp4 = 32'h44;
        run_mul(o, 32'd0, 32'hFFFFFFFD, 32'd3, "mul_max");
        o = mkop(3'd6, 32'd0, 32'd0, 32'd0, 1'b0, 2'b01, 2'b10, 32'd6, 1'b0, 32'd0, 5'd8, 1'b1);
        o.memw = 1'b1; o.pcp4 = 32'h48;
        run_mul(o, 32'd1000, 32'hFFFFFFEE, 32'hFFFFFFFD, "mul_b2b");

        // Reset during BUSY iteration 10, then a fresh 6x7.
        o = mkop(3'd6, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd9, 1'b1);
        apply(o);
        for (int k = 0; k < 11; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_result", bus.ALUResultM, 32'd0);
        chk("abort_ctl", ctl_bundle(), 32'd0);
        chk("abort_stall_mul", {31'd0, bus.StallEx}, 32'd1);
        o.ctrl = 3'd0;
        apply(o);
        #1;
        chk("abort_stall_add", {31'd0, bus.StallEx}, 32'd0);
        $display("txn abort res=%h stall=%0d", bus.ALUResultM, bus.StallEx);
        model_alu_m = 32'd0;
        o = mkop(3'd6, 32'd6, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd4, 1'b1);
        o.pcp4 = 32'h80;
        run_mul(o, 32'd5, 32'd42, 32'd7, "mul_after_rst");

        // Randomized traffic against the reference model.
        codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        for (int n = 0; n < 150; n++) begin
            o.rd1    = $urandom;
            o.rd2    = ($urandom_range(0, 3) == 0) ? o.rd1 : $urandom;
            o.imm    = $urandom;
            o.pce    = $urandom;
            o.pcp4   = $urandom;
            o.resw   = $urandom;
            o.rd     = 5'($urandom_range(0, 31));
            o.fa     = 2'($urandom_range(0, 3));
            o.fb     = 2'($urandom_range(0, 3));
            o.regw   = 1'($urandom_range(0, 1));
            o.memw   = 1'($urandom_range(0, 1));
            o.ressrc = 1'($urandom_range(0, 1));
            o.branch = 1'($urandom_range(0, 1));
            o.alusrc = 1'($urandom_range(0, 1));
            sa = ref_fwd(o.fa, o.rd1, o.resw);
            wd = ref_fwd(o.fb, o.rd2, o.resw);
            if ($urandom_range(0, 7) == 0) begin
                o.ctrl   = 3'd6;
                o.alusrc = 1'b0;
                prod     = 64'(sa) * 64'(wd);
                run_mul(o, $urandom, prod[31:0], wd, $sformatf("rnd%0d", n));
            end else begin
                o.ctrl = codes[$urandom_range(0, 6)];
                sb     = o.alusrc ? o.imm : wd;
                res    = ref_alu(o.ctrl, sa, sb);
                run_single(o, res, wd, o.pce + o.imm, o.branch && (res == 32'd0),
                           $sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
